// File: rtl/system_parameters_loader.sv
// Avalon-MM initiator that loads the system_parameters_* PIO slaves from a {select,data}
// command stream, optionally reading each value back and flagging mismatches.
module system_parameters_loader #(
   parameter int NUM_SLAVES = 8,
   parameter int SEL_W      = 4,
   parameter int ADDR_W     = 2,
   parameter int VERIFY     = 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [SEL_W-1:0]         cmd_sel,
   input  logic [31:0]              cmd_data,
   output logic [NUM_SLAVES-1:0]    avm_chipselect,
   output logic [ADDR_W-1:0]        avm_address,
   output logic                     avm_write_n,
   output logic [31:0]              avm_writedata,
   input  logic [NUM_SLAVES*32-1:0] avm_readdata_flat,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic [15:0]              err_count,
   input  logic                     err_clr,
   output logic [31:0]              last_readback
);

   typedef enum logic [2:0] {IDLE, WR, RD, CHK, FIN} state_t;

   state_t                  state_q;
   logic [SEL_W-1:0]        sel_q;
   logic [31:0]             data_q;
   logic                    cmdReady_q;
   logic [NUM_SLAVES-1:0]   chipSelect_q;
   logic                    writeN_q;
   logic [31:0]             writeData_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    err_q;
   logic [15:0]             errCount_q;
   logic [15:0]             errCount_d;
   logic [31:0]             lastReadback_q;

   logic                    selValid;
   logic [NUM_SLAVES-1:0]   csForCmd;
   logic [31:0]             readSlice;

   // An out-of-range select matches no index, so it can never raise a chipselect.
   always_comb begin
      selValid = (int'(cmd_sel) < NUM_SLAVES);
      csForCmd = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         csForCmd[i] = (int'(cmd_sel) == i);
      end
   end

   always_comb begin
      readSlice = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (int'(sel_q) == i) begin
            readSlice = avm_readdata_flat[32*i +: 32];
         end
      end
   end

   // Counting on the cycle err is visible lets err_clr in that same cycle override it.
   always_comb begin
      errCount_d = errCount_q;
      if (err_clr) begin
         errCount_d = '0;
      end else if (err_q && (errCount_q != 16'hFFFF)) begin
         errCount_d = errCount_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         errCount_q <= '0;
      end else begin
         errCount_q <= errCount_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         sel_q          <= '0;
         data_q         <= '0;
         cmdReady_q     <= 1'b0;
         chipSelect_q   <= '0;
         writeN_q       <= 1'b1;
         writeData_q    <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
         lastReadback_q <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cmdReady_q && cmd_valid) begin
                  sel_q      <= cmd_sel;
                  data_q     <= cmd_data;
                  cmdReady_q <= 1'b0;
                  busy_q     <= 1'b1;
                  if (selValid) begin
                     state_q      <= WR;
                     chipSelect_q <= csForCmd;
                     writeN_q     <= 1'b0;
                     writeData_q  <= cmd_data;
                  end else begin
                     state_q <= FIN;
                     done_q  <= 1'b1;
                     err_q   <= 1'b1;
                  end
               end else begin
                  cmdReady_q <= 1'b1;
               end
            end
            WR: begin
               writeN_q <= 1'b1;
               if (VERIFY != 0) begin
                  state_q <= RD;
               end else begin
                  state_q      <= FIN;
                  chipSelect_q <= '0;
                  done_q       <= 1'b1;
               end
            end
            RD: begin
               state_q        <= CHK;
               chipSelect_q   <= '0;
               lastReadback_q <= readSlice;
               done_q         <= 1'b1;
               err_q          <= (readSlice != data_q);
            end
            CHK, FIN: begin
               state_q    <= IDLE;
               cmdReady_q <= 1'b1;
               busy_q     <= 1'b0;
            end
            default: begin
               state_q      <= IDLE;
               chipSelect_q <= '0;
               writeN_q     <= 1'b1;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready      = cmdReady_q;
   assign avm_chipselect = chipSelect_q;
   assign avm_address    = '0;
   assign avm_write_n    = writeN_q;
   assign avm_writedata  = writeData_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign err            = err_q;
   assign err_count      = errCount_q;
   assign last_readback  = lastReadback_q;

endmodule
